data_island_packet_serializer: RTL and testbench

//  Downstream of the packet selector: takes the chosen 24-bit header and four 56-bit subpackets,

---
 rtl/data_island_packet_serializer.sv | 131 +++++++++++++
 tb/tb_data_island_packet_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_island_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module  : data_island_packet_serializer
// Brief   : Appends BCH parity to a data island header and four subpackets and
//           serialises them as 9 TERC4 payload bits per pixel over 32 pixels.
//           Optional DATA_ISLAND_OUTPUT_REG_EN adds one output register stage.
// Revision: 1.0 - initial release
// ============================================================================
module data_island_packet_serializer #(
    parameter logic [7:0] ECC_POLY = 8'h83
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        data_island_period,
    input  logic [23:0] header,
    input  logic [55:0] sub [3:0],
    output logic [4:0]  counter,
    output logic [8:0]  packet_data,
    output logic        packet_end
);
    localparam logic [4:0] c_HDR_PIXELS = 5'd24;
    localparam logic [4:0] c_SUB_PIXELS = 5'd28;
    localparam logic [4:0] c_LAST_PIXEL = 5'd31;

    function automatic logic [7:0] bch_step(input logic [7:0] p, input logic b);
        return {1'b0, p[7:1]} ^ ((p[0] ^ b) ? ECC_POLY : 8'h00);
    endfunction

    logic [4:0]  r_counter;
    logic [7:0]  r_hdr_ecc;
    logic [7:0]  r_sub_ecc [4];
    logic [23:0] r_header_hold;
    logic [55:0] r_sub_hold [4];

    logic        w_first;
    logic        w_hdr_lane;
    logic        w_sub_lane;
    logic [23:0] w_header;
    logic        w_hdr_bit;
    logic [7:0]  w_hdr_next;
    logic        w_ch0;
    logic [3:0]  w_ch1;
    logic [3:0]  w_ch2;
    logic [7:0]  w_sub_next [4];
    logic [4:0]  w_counter;
    logic [8:0]  w_packet_data;
    logic        w_packet_end;

    // Pixel 0 works from the live inputs and a zero parity seed, so nothing
    // from a previous or aborted packet can leak into the new one.
    assign w_first    = (r_counter == 5'd0);
    assign w_hdr_lane = (r_counter < c_HDR_PIXELS);
    assign w_sub_lane = (r_counter < c_SUB_PIXELS);
    assign w_header   = w_first ? header : r_header_hold;
    assign w_hdr_bit  = w_header[r_counter];
    assign w_hdr_next = bch_step(w_first ? 8'h00 : r_hdr_ecc, w_hdr_bit);
    assign w_ch0      = w_hdr_lane ? w_hdr_bit : r_hdr_ecc[r_counter[2:0]];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [55:0] w_sub_cur;
        logic        w_bit_lo;
        logic        w_bit_hi;
        logic [7:0]  w_mid;

        assign w_sub_cur       = w_first ? sub[gi] : r_sub_hold[gi];
        assign w_bit_lo        = w_sub_cur[{r_counter, 1'b0}];
        assign w_bit_hi        = w_sub_cur[{r_counter, 1'b1}];
        assign w_mid           = bch_step(w_first ? 8'h00 : r_sub_ecc[gi], w_bit_lo);
        assign w_sub_next[gi]  = bch_step(w_mid, w_bit_hi);
        assign w_ch1[gi]       = w_sub_lane ? w_bit_lo : r_sub_ecc[gi][{r_counter[1:0], 1'b0}];
        assign w_ch2[gi]       = w_sub_lane ? w_bit_hi : r_sub_ecc[gi][{r_counter[1:0], 1'b1}];
    end

    assign w_counter     = data_island_period ? r_counter : 5'd0;
    assign w_packet_data = data_island_period ? {w_ch2, w_ch1, w_ch0} : 9'd0;
    assign w_packet_end  = data_island_period && (r_counter == c_LAST_PIXEL);

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_counter     <= 5'd0;
            r_hdr_ecc     <= 8'h00;
            r_header_hold <= 24'd0;
            for (int i = 0; i < 4; i++) begin
                r_sub_ecc[i]  <= 8'h00;
                r_sub_hold[i] <= 56'd0;
            end
        end else if (!data_island_period) begin
            r_counter <= 5'd0;
            r_hdr_ecc <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                r_sub_ecc[i] <= 8'h00;
            end
        end else begin
            r_counter <= r_counter + 5'd1;
            if (w_first) begin
                r_header_hold <= header;
                for (int i = 0; i < 4; i++) begin
                    r_sub_hold[i] <= sub[i];
                end
            end
            if (w_hdr_lane) begin
                r_hdr_ecc <= w_hdr_next;
            end
            if (w_sub_lane) begin
                for (int i = 0; i < 4; i++) begin
                    r_sub_ecc[i] <= w_sub_next[i];
                end
            end
        end
    end

`ifdef DATA_ISLAND_OUTPUT_REG_EN
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter     <= 5'd0;
            packet_data <= 9'd0;
            packet_end  <= 1'b0;
        end else begin
            counter     <= w_counter;
            packet_data <= w_packet_data;
            packet_end  <= w_packet_end;
        end
    end
`else
    assign counter     = w_counter;
    assign packet_data = w_packet_data;
    assign packet_end  = w_packet_end;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_island_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_island_packet_serializer
// Brief   : Self-checking bench: packet-level BCH model plus literal checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_island_packet_serializer;
    localparam logic [7:0] c_POLY = 8'h83;
`ifdef DATA_ISLAND_OUTPUT_REG_EN
    localparam bit c_REG = 1'b1;
`else
    localparam bit c_REG = 1'b0;
`endif

    logic        clk_pixel;
    logic        reset;
    logic        data_island_period;
    logic [23:0] header;
    logic [55:0] sub [3:0];
    logic [4:0]  counter;
    logic [8:0]  packet_data;
    logic        packet_end;

    int          n_cmp;
    int          n_bad;
    bit          chk_en;
    int          lit;

    logic [4:0]  m_k;
    logic [23:0] m_h;
    logic [55:0] m_s [4];
    logic [14:0] exp_c;
    logic [14:0] exp_q;
    logic [14:0] exp_now;
    logic [8:0]  lit_exp;

    data_island_packet_serializer #(.ECC_POLY(c_POLY)) dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .counter            (counter),
        .packet_data        (packet_data),
        .packet_end         (packet_end)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Parity of the first n bits of a word, LSB sent first.
    function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < n; i++) begin
            p = {1'b0, p[7:1]} ^ ((p[0] ^ bits[i]) ? c_POLY : 8'h00);
        end
        return p;
    endfunction

    // Whole packet laid out as serial streams; pixel k picks its bits.
    function automatic logic [8:0] pix(input logic [23:0] h, input logic [55:0] s0,
                                       input logic [55:0] s1, input logic [55:0] s2,
                                       input logic [55:0] s3, input int k);
        logic [31:0] hs;
        logic [63:0] ss [4];
        logic [8:0]  r;
        hs    = {bch({40'd0, h}, 24), h};
        ss[0] = {bch({8'd0, s0}, 56), s0};
        ss[1] = {bch({8'd0, s1}, 56), s1};
        ss[2] = {bch({8'd0, s2}, 56), s2};
        ss[3] = {bch({8'd0, s3}, 56), s3};
        r[0]  = hs[k];
        for (int i = 0; i < 4; i++) begin
            r[1 + i] = ss[i][2 * k];
            r[5 + i] = ss[i][2 * k + 1];
        end
        return r;
    endfunction

    function automatic logic [8:0] lit2(input logic [4:0] k);
        case (k)
            5'd23, 5'd24, 5'd25, 5'd31: return 9'h001;
            default:                    return 9'h000;
        endcase
    endfunction

    function automatic logic [8:0] lit3(input logic [4:0] k);
        case (k)
            5'd27, 5'd31: return 9'h020;
            5'd28:        return 9'h022;
            default:      return 9'h000;
        endcase
    endfunction

    always_comb begin
        exp_c = '0;
        if (data_island_period) begin
            exp_c[14:10] = m_k;
            exp_c[9]     = (m_k == 5'd31);
            if (m_k == 5'd0)
                exp_c[8:0] = pix(header, sub[0], sub[1], sub[2], sub[3], 0);
            else
                exp_c[8:0] = pix(m_h, m_s[0], m_s[1], m_s[2], m_s[3], int'(m_k));
        end
    end

    always @(posedge clk_pixel) begin
        exp_q <= reset ? 15'd0 : exp_c;
        if (reset || !data_island_period) begin
            m_k <= 5'd0;
        end else begin
            if (m_k == 5'd0) begin
                m_h <= header;
                for (int i = 0; i < 4; i++) m_s[i] <= sub[i];
            end
            m_k <= m_k + 5'd1;
        end
    end

    always @(negedge clk_pixel) begin
        if (chk_en) begin
            exp_now = c_REG ? exp_q : exp_c;
            n_cmp++;
            if ({counter, packet_end, packet_data} !== exp_now) begin
                n_bad++;
                $display("FAIL model t=%0t got counter=%0d end=%0b data=%h want counter=%0d end=%0b data=%h",
                         $time, counter, packet_end, packet_data,
                         exp_now[14:10], exp_now[9], exp_now[8:0]);
            end
            if ((lit == 1) || ((lit == 2) && (counter >= 5'd23)) || ((lit == 3) && (counter >= 5'd27))) begin
                lit_exp = (lit == 2) ? lit2(counter) : (lit == 3) ? lit3(counter) : 9'h000;
                n_cmp++;
                if (packet_data !== lit_exp || (lit == 1 && packet_end !== (counter == 5'd31))) begin
                    n_bad++;
                    $display("FAIL literal%0d t=%0t counter=%0d got data=%h end=%0b want data=%h",
                             lit, $time, counter, packet_data, packet_end, lit_exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pixel);
            #1;
            reset              = 1'b0;
            data_island_period = 1'b0;
        end
    endtask

    task automatic run_pkt(input logic [23:0] h, input logic [55:0] s0, input bit fill,
                           input int n, input int chg_at);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_pixel);
            #1;
            reset              = 1'b0;
            data_island_period = 1'b1;
            if (k == 0) begin
                header = h;
                sub[0] = s0;
                sub[1] = fill ? ~s0 : 56'd0;
                sub[2] = fill ? {s0[27:0], s0[55:28]} : 56'd0;
                sub[3] = fill ? 56'h00FF00FF00FF00 : 56'd0;
            end
            if (k == chg_at) begin
                header = 24'h5A5A5A;
                for (int i = 0; i < 4; i++) sub[i] = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_en = 1'b0;
        lit = 0;
        m_k = 5'd0;
        reset = 1'b1;
        data_island_period = 1'b0;
        header = 24'd0;
        for (int i = 0; i < 4; i++) sub[i] = 56'd0;
        @(posedge clk_pixel);
        #1;
        chk_en = 1'b1;
        @(posedge clk_pixel);
        #2;
        n_cmp++;
        if (counter !== 5'd0 || packet_data !== 9'd0 || packet_end !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got counter=%0d data=%h end=%0b want 0/000/0",
                     counter, packet_data, packet_end);
        end

        idle(2); lit = 1; run_pkt(24'd0, 56'd0, 1'b0, 32, -1);
        idle(2); lit = 2; run_pkt(24'h800000, 56'd0, 1'b0, 32, -1);
        idle(2); lit = 3; run_pkt(24'd0, 56'h80000000000000, 1'b0, 32, -1);
        idle(2); lit = 2; run_pkt(24'h800000, 56'd0, 1'b0, 32, 5);
        idle(2); lit = 3; run_pkt(24'd0, 56'h80000000000000, 1'b0, 32, 5);
        idle(2); lit = 0; run_pkt(24'hA5C3F0, 56'h0123456789ABCD, 1'b1, 32, -1);
        run_pkt(24'd0, 56'd0, 1'b0, 32, -1);
        idle(2); lit = 2; run_pkt(24'h800000, 56'd0, 1'b0, 10, -1);
        idle(1); run_pkt(24'h800000, 56'd0, 1'b0, 32, -1);
        idle(2); run_pkt(24'h800000, 56'd0, 1'b0, 10, -1);
        @(posedge clk_pixel);
        #1;
        reset = 1'b1;
        data_island_period = 1'b1;
        run_pkt(24'h800000, 56'd0, 1'b0, 32, -1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
